adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Shares a single `Adder` datapath instance between `NUM_REQ` requesters. Each requester presents two `SIZE`-bit operands with a request. The block picks one winner, registers its operands, and drives the shared adder. It then holds the `(SIZE+1)`-bit sum with a valid/ack handshake until the winner consumes it. It sits between client blocks and the adder so the adder is never duplicated per client.

## Interface
Parameters:
- `SIZE`, 4: operand width in bits; the sum is `SIZE+1` bits.
- `NUM_REQ`, 4: number of requesters, ≥2. The index width is `$clog2(NUM_REQ)`.

Ports:
- `i_CLK`, input, 1: single clock; all state updates on the rising edge.
- `i_RESET_N`, input, 1: asynchronous, active-low reset.
- `i_REQ`, input, `NUM_REQ`: per-requester request, level.
- `i_VECTOR_ONE`, input, `NUM_REQ*SIZE`: first operands, flattened; requester k occupies bits `[k*SIZE +: SIZE]`.
- `i_VECTOR_TWO`, input, `NUM_REQ*SIZE`: second operands, same packing.
- `i_ACK`, input, 1: winner consumes the result.
- `o_GRANT`, output, `NUM_REQ`: one-hot grant; all zeros when idle.
- `o_VECTOR_SUM`, output, `SIZE+1`: registered sum, carry in the MSB.
- `o_VALID`, output, 1: `o_VECTOR_SUM` is valid for the granted requester.
- `o_BUSY`, output, 1: the state machine is not in IDLE.

## Operation
State machine states are IDLE, CALC and DONE.
- **IDLE**
  - If `i_REQ` is nonzero, select the winner using the selection policy (see Configuration).
  - Capture the winner's operands into `op_one` and `op_two`, the winner index into `win`, and the one-hot grant. Go to CALC.
  - Otherwise stay in IDLE.
- **CALC**
  - The shared adder sees the registered operands only.
  - Register the adder output into `o_VECTOR_SUM`. Go to DONE.
- **DONE**
  - `o_VALID` is 1.
  - On `i_ACK`=1: clear `o_VALID` and the grant, set the round-robin pointer to `win+1` (mod `NUM_REQ`), and go to IDLE.
  - Otherwise hold all outputs.
- **Arithmetic:** the sum is the full `SIZE+1`-bit sum of unsigned operands; it never truncates or wraps. Carry-in is 0.
- **Request/operand rules**
  - A requester holds its operands stable while its request is asserted and before the grant.
  - Operands are sampled once, in IDLE; later operand changes are ignored.
- **Request drop:** if the winner drops `i_REQ` during CALC or DONE, the operation completes and waits for `i_ACK` regardless.
- **Stray ack:** `i_ACK` in IDLE or CALC is ignored.
- **Re-request:** a requester still requesting after its ack competes again in the next IDLE cycle.
- **Reset (any time, including mid-operation):** state goes to IDLE, pointer to 0, and these outputs take their reset values:
  - `o_GRANT` = 0
  - `o_VECTOR_SUM` = 0
  - `o_VALID` = 0
  - `o_BUSY` = 0

## Timing
- Request sampled at edge k (state IDLE):
  - `o_GRANT` and `o_BUSY` assert after edge k.
  - `o_VALID` asserts after edge k+1.
- Ack sampled at edge j (state DONE): `o_VALID`, `o_GRANT` and `o_BUSY` deassert after edge j. The next grant is possible at edge j+1.
- Minimum period is 3 cycles per operation, with ack arriving in the first DONE cycle. Latency from request to valid is 2 cycles.
- `o_GRANT` is stable from the edge that enters CALC until the edge that leaves DONE.
- Outputs are registered; `o_VALID` has no combinational path from `i_ACK` or `i_REQ`.

## Configuration
- Macro `ADDER_ARB_ROUND_ROBIN_EN` selects the winner-selection policy.
- **Defined:** round-robin.
  - The search starts at the pointer and moves upward with wrap; the first asserted request wins.
  - The pointer advances to `win+1` on ack.
- **Undefined:** fixed priority.
  - The lowest asserted index always wins.
  - The pointer register and its logic are not built.

## Structure
- **Package `adder_arb_pkg`:**
  - State encoding constants `ST_IDLE`=2'd0, `ST_CALC`=2'd1, `ST_DONE`=2'd2.
  - Default `SIZE` and `NUM_REQ`.
  - An index-width helper function.
- **Shared datapath:** one instance of the existing `Adder` with `SIZE` passed through. Operands come from the registered `op_one` and `op_two`.
- **Sub-module `rr_select`:** takes the request vector and pointer; outputs a one-hot winner and its index. It is purely combinational, and fixed priority is used when the macro is undefined.

## Test plan
All scenarios use `SIZE`=4 and `NUM_REQ`=4.
- **Reset mid-operation:** pull `i_RESET_N` low while in DONE. Required response:
  - `o_VALID`, `o_GRANT`, `o_VECTOR_SUM` and `o_BUSY` become 0 asynchronously.
  - After reset release, `i_REQ`=4'b0011 grants `o_GRANT`=4'b0001.
- **Single request:** `i_REQ`=4'b0100, req2 operands 4'h3 and 4'h5. Required response:
  - `o_GRANT`=4'b0100 after 1 cycle.
  - `o_VALID`=1 with `o_VECTOR_SUM`=5'h08 after 2 cycles.
  - After ack, all outputs are 0.
- **Carry out:** operands 4'hF and 4'h1 → `o_VECTOR_SUM`=5'h10. Operands 4'hF and 4'hF → 5'h1E.
- **Round-robin fairness (macro defined):** `i_REQ`=4'b1111 held, ack at every DONE. Required response:
  - Grants cycle 0001, 0010, 0100, 1000, 0001.
  - Without the macro, every grant is 0001.
- **Held result:** `i_ACK` held low for 10 cycles in DONE.
  - Required response: `o_VALID` and `o_VECTOR_SUM` stay stable even if the winner's operands change or `i_REQ` drops.
- **Ack outside DONE:** `i_ACK`=1 in CALC.
  - Required response: ignored; DONE is still entered and `o_VALID` asserts.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for adder_share_arbiter and its sub-blocks.
package adder_arb_pkg;

    localparam int DEFAULT_SIZE    = 4;
    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// Shared unsigned adder datapath: full SIZE+1-bit sum, carry-in of zero.
module Adder #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] i_A,
    input  logic [SIZE-1:0] i_B,
    output logic [SIZE:0]   o_SUM
);

    assign o_SUM = {1'b0, i_A} + {1'b0, i_B};

endmodule

// File: rtl/adder_share_arbiter_rr_select.sv
// Combinational winner selection: round-robin from i_PTR when
// ADDER_ARB_ROUND_ROBIN_EN is defined, lowest-index fixed priority otherwise.
module rr_select
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_REQ,
    input  logic [IDX_W-1:0]   i_PTR,
    output logic [NUM_REQ-1:0] o_GRANT,
    output logic [IDX_W-1:0]   o_IDX
);

    logic found;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_GRANT = '0;
        o_IDX   = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_REQ[(int'(i_PTR) + i) % NUM_REQ]) begin
                found                                    = 1'b1;
                o_GRANT[(int'(i_PTR) + i) % NUM_REQ]     = 1'b1;
                o_IDX                                    = IDX_W'((int'(i_PTR) + i) % NUM_REQ);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^i_PTR;

    always_comb begin
        o_GRANT = '0;
        o_IDX   = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_REQ[i]) begin
                found      = 1'b1;
                o_GRANT[i] = 1'b1;
                o_IDX      = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared Adder with a valid/ack result.
// Macro ADDER_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int SIZE    = DEFAULT_SIZE,
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET_N,
    input  logic [NUM_REQ-1:0]      i_REQ,
    input  logic [NUM_REQ*SIZE-1:0] i_VECTOR_ONE,
    input  logic [NUM_REQ*SIZE-1:0] i_VECTOR_TWO,
    input  logic                    i_ACK,
    output logic [NUM_REQ-1:0]      o_GRANT,
    output logic [SIZE:0]           o_VECTOR_SUM,
    output logic                    o_VALID,
    output logic                    o_BUSY
);

    state_t             state_q, state_d;
    logic [SIZE-1:0]    op_one_q, op_one_d;
    logic [SIZE-1:0]    op_two_q, op_two_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SIZE:0]      sum_q, sum_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   ptr;

    logic [NUM_REQ-1:0] sel_grant;
    logic [IDX_W-1:0]   sel_idx;
    logic [SIZE:0]      adder_sum;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .i_REQ   (i_REQ),
        .i_PTR   (ptr),
        .o_GRANT (sel_grant),
        .o_IDX   (sel_idx)
    );

    // The adder only ever sees the operands captured in IDLE.
    Adder #(.SIZE(SIZE)) u_adder (
        .i_A   (op_one_q),
        .i_B   (op_two_q),
        .o_SUM (adder_sum)
    );

    always_comb begin
        state_d  = state_q;
        op_one_d = op_one_q;
        op_two_d = op_two_q;
        win_d    = win_q;
        grant_d  = grant_q;
        sum_d    = sum_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|i_REQ) begin
                    op_one_d = i_VECTOR_ONE[int'(sel_idx)*SIZE +: SIZE];
                    op_two_d = i_VECTOR_TWO[int'(sel_idx)*SIZE +: SIZE];
                    win_d    = sel_idx;
                    grant_d  = sel_grant;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                sum_d   = adder_sum;
                valid_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ACK) begin
                    sum_d   = '0;
                    valid_d = 1'b0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
                    ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef ADDER_ARB_ROUND_ROBIN_EN
    logic unused_win;
    assign unused_win = ^win_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q  <= ST_IDLE;
            op_one_q <= '0;
            op_two_q <= '0;
            win_q    <= '0;
            grant_q  <= '0;
            sum_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_one_q <= op_one_d;
            op_two_q <= op_two_d;
            win_q    <= win_d;
            grant_q  <= grant_d;
            sum_q    <= sum_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign o_GRANT      = grant_q;
    assign o_VECTOR_SUM = sum_q;
    assign o_VALID      = valid_q;
    assign o_BUSY       = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized self-checking bench for adder_share_arbiter (SIZE=4, NUM_REQ=4).
module tb_adder_share_arbiter;

    localparam int SIZE    = 4;
    localparam int NUM_REQ = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      i_REQ;
    logic [NUM_REQ*SIZE-1:0] i_VECTOR_ONE;
    logic [NUM_REQ*SIZE-1:0] i_VECTOR_TWO;
    logic                    i_ACK;
    logic [NUM_REQ-1:0]      o_GRANT;
    logic [SIZE:0]           o_VECTOR_SUM;
    logic                    o_VALID;
    logic                    o_BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    adder_share_arbiter #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) dut (
        .i_CLK        (clk),
        .i_RESET_N    (rst_n),
        .i_REQ        (i_REQ),
        .i_VECTOR_ONE (i_VECTOR_ONE),
        .i_VECTOR_TWO (i_VECTOR_TWO),
        .i_ACK        (i_ACK),
        .o_GRANT      (o_GRANT),
        .o_VECTOR_SUM (o_VECTOR_SUM),
        .o_VALID      (o_VALID),
        .o_BUSY       (o_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner chosen by the policy rules: scan upward from the pointer with wrap
    // (round-robin) or take the lowest requesting index (fixed priority).
    function automatic int model_winner(input logic [NUM_REQ-1:0] req);
        int start;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        start = model_ptr;
`else
        start = 0;
`endif
        for (int i = 0; i < NUM_REQ; i++)
            if (req[(start + i) % NUM_REQ]) return (start + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(o_GRANT), 32'h0);
        check({tag, "_valid"}, 32'(o_VALID), 32'h0);
        check({tag, "_busy"},  32'(o_BUSY),  32'h0);
        check({tag, "_sum"},   32'(o_VECTOR_SUM), 32'h0);
    endtask

    // One full transaction: request, CALC, DONE held for 'delay' cycles, ack.
    task automatic do_op(input logic [NUM_REQ-1:0] req, input logic [15:0] v1,
                         input logic [15:0] v2, input int delay, input bit stray,
                         input bit drop, input bit keep_req);
        int w;
        int a;
        int b;
        logic [NUM_REQ-1:0] eg;
        i_REQ        = req;
        i_VECTOR_ONE = v1;
        i_VECTOR_TWO = v2;
        w  = model_winner(req);
        a  = int'(v1[w*SIZE +: SIZE]);
        b  = int'(v2[w*SIZE +: SIZE]);
        eg = NUM_REQ'(1) << w;
        tick();
        check("grant_calc", 32'(o_GRANT), 32'(eg));
        check("busy_calc",  32'(o_BUSY),  32'h1);
        check("valid_calc", 32'(o_VALID), 32'h0);
        i_VECTOR_ONE = 16'($urandom);
        i_VECTOR_TWO = 16'($urandom);
        if (drop) i_REQ = '0;
        i_ACK = stray;
        tick();
        check("valid_done", 32'(o_VALID), 32'h1);
        check("sum_done",   32'(o_VECTOR_SUM), 32'(a + b));
        check("grant_done", 32'(o_GRANT), 32'(eg));
        if (delay > 0) begin
            i_ACK = 1'b0;
            for (int c = 0; c < delay; c++) begin
                i_VECTOR_ONE = 16'($urandom);
                i_VECTOR_TWO = 16'($urandom);
                if (drop) i_REQ = '0;
                tick();
                check("valid_hold", 32'(o_VALID), 32'h1);
                check("sum_hold",   32'(o_VECTOR_SUM), 32'(a + b));
                check("grant_hold", 32'(o_GRANT), 32'(eg));
                check("busy_hold",  32'(o_BUSY), 32'h1);
            end
        end
        i_ACK = 1'b1;
        tick();
        check_idle("after_ack");
        i_ACK = 1'b0;
        if (!keep_req) i_REQ = '0;
        model_ptr = (w + 1) % NUM_REQ;
    endtask

    initial begin
        rst_n        = 1'b0;
        i_REQ        = '0;
        i_VECTOR_ONE = '0;
        i_VECTOR_TWO = '0;
        i_ACK        = 1'b0;
        #12;
        check_idle("reset");
        #10 rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Fairness: all requesting, ack in first DONE cycle, back-to-back.
        for (int n = 0; n < 5; n++) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            check("rr_ptr_model", 32'(model_winner(4'b1111)), 32'(n % NUM_REQ));
`else
            check("fp_ptr_model", 32'(model_winner(4'b1111)), 32'h0);
`endif
            do_op(4'b1111, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0, 1'b1);
        end
        i_REQ = '0;
        tick();
        check_idle("idle_gap");

        // Single request and carry cases.
        do_op(4'b0100, 16'h0300, 16'h0500, 0, 1'b0, 1'b0, 1'b0);
        do_op(4'b0001, 16'h000F, 16'h0001, 1, 1'b0, 1'b0, 1'b0);
        do_op(4'b0010, 16'h00F0, 16'h00F0, 0, 1'b0, 1'b0, 1'b0);

        // Held result with dropped request and changing operands; stray ack in CALC.
        do_op(4'b1000, 16'h9000, 16'h6000, 10, 1'b0, 1'b1, 1'b0);
        do_op(4'b0010, 16'h00A0, 16'h0070, 2, 1'b1, 1'b0, 1'b0);

        // Reset while in DONE.
        i_REQ        = 4'b0001;
        i_VECTOR_ONE = 16'h0007;
        i_VECTOR_TWO = 16'h0006;
        tick();
        tick();
        check("pre_rst_valid", 32'(o_VALID), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        model_ptr = 0;
        i_REQ = '0;
        #4 rst_n = 1'b1;
        tick();
        check_idle("after_mid_reset");
        do_op(4'b0011, 16'h0021, 16'h0043, 0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            do_op(NUM_REQ'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                i_REQ = '0;
                tick();
                check_idle("rand_idle");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
